// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Retires BITS_PER_CYCLE quotient bits per clock and returns {remainder, quotient}.
module div_seq #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int unsigned Steps = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StByZero = 2'd1;
  localparam logic [1:0] StOn     = 2'd2;
  localparam logic [1:0] StEnd    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]    dvd_q, dvd_d;
  logic [DATA_W-1:0]    dsr_q, dsr_d;
  logic [DATA_W:0]      rem_q, rem_d;
  logic [DATA_W-1:0]    quot_q, quot_d;
  logic                 sgn_q, sgn_d;
  logic                 neg1_q, neg1_d;
  logic                 neg2_q, neg2_d;
  logic [2*DATA_W-1:0]  result_q, result_d;

  logic [DATA_W-1:0]    dvd_n, quot_n;
  logic [DATA_W:0]      rem_n;
  logic [DATA_W+1:0]    rem_t, diff;
  logic [DATA_W-1:0]    quot_fix, rem_fix;

  // One clock's worth of restoring steps; diff MSB is the trial-subtract borrow.
  always_comb begin
    dvd_n  = dvd_q;
    rem_n  = rem_q;
    quot_n = quot_q;
    rem_t  = '0;
    diff   = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      rem_t = {rem_n, dvd_n[DATA_W-1]};
      diff  = rem_t - {2'b00, dsr_q};
      dvd_n = dvd_n << 1;
      if (!diff[DATA_W+1]) begin
        rem_n  = diff[DATA_W:0];
        quot_n = {quot_n[DATA_W-2:0], 1'b1};
      end else begin
        rem_n  = rem_t[DATA_W:0];
        quot_n = {quot_n[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    quot_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -quot_n : quot_n;
    rem_fix  = (sgn_q && neg1_q) ? -rem_n[DATA_W-1:0] : rem_n[DATA_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
            sgn_d   = signed_i;
            neg1_d  = opdata1_i[DATA_W-1];
            neg2_d  = opdata2_i[DATA_W-1];
            dvd_d   = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
            dsr_d   = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
            cnt_d   = '0;
            rem_d   = '0;
            quot_d  = '0;
          end
        end
      end
      StByZero: begin
        result_d = '0;
        state_d  = StEnd;
      end
      StOn: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          dvd_d  = dvd_n;
          rem_d  = rem_n;
          quot_d = quot_n;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(Steps - 1)) begin
            state_d  = StEnd;
            result_d = {rem_fix, quot_fix};
          end
        end
      end
      StEnd: begin
        if (!start_i || annul_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == StEnd);
  assign stallreq_o = ((state_q == StIdle) && start_i && !annul_i) ||
                      (state_q == StByZero) ||
                      ((state_q == StOn) && !annul_i);

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: 32-bit/1-bit-per-cycle and 16-bit/4-bit-per-cycle instances
// checked against an arithmetic reference with a per-cycle output compare.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 0, annul_a = 0, sgn_a = 0;
  logic [31:0] op1_a = 0, op2_a = 0;
  logic [63:0] res_a;
  logic        rdy_a, stall_a;

  logic        start_b = 0, annul_b = 0, sgn_b = 0;
  logic [15:0] op1_b = 0, op2_b = 0;
  logic [31:0] res_b;
  logic        rdy_b, stall_b;

  div_seq #(.DATA_W(32), .BITS_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .rst(rst), .signed_i(sgn_a), .start_i(start_a), .annul_i(annul_a),
    .opdata1_i(op1_a), .opdata2_i(op2_a), .result_o(res_a), .ready_o(rdy_a),
    .stallreq_o(stall_a)
  );

  div_seq #(.DATA_W(16), .BITS_PER_CYCLE(4)) u_dut_b (
    .clk(clk), .rst(rst), .signed_i(sgn_b), .start_i(start_b), .annul_i(annul_b),
    .opdata1_i(op1_b), .opdata2_i(op2_b), .result_o(res_b), .ready_o(rdy_b),
    .stallreq_o(stall_b)
  );

  int n_chk = 0;
  int n_err = 0;

  logic        chk_en = 0;
  logic        exp_ready = 0, exp_stall = 0;
  logic [63:0] exp_res = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Truncating division on sign-extended 64-bit values; zero divisor yields 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn, input int w);
    longint m, sa, sb, q, r;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sb == 0) return 64'd0;
    if (sgn && ((sa >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
    if (sgn && ((sb >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
    q = sa / sb;
    r = sa % sb;
    return 64'(((r & m) << w) | (q & m));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {63'd0, rdy_a}, {63'd0, exp_ready});
      check("stall", {63'd0, stall_a}, {63'd0, exp_stall});
      check("result", res_a, exp_res);
    end
  end

  // Full operation on instance A; ends in an IDLE cycle with start low.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    int lat;
    lat = (b == 0) ? 2 : 33;
    @(posedge clk); #1;
    start_a = 1; annul_a = 0; sgn_a = sgn; op1_a = a; op2_a = b;
    exp_ready = 0; exp_stall = 1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      op1_a = $urandom; op2_a = $urandom; sgn_a = 1'($urandom);
      if (k == lat) begin
        exp_ready = 1; exp_stall = 0; exp_res = model(a, b, sgn, 32);
      end
    end
    @(posedge clk); #1;
    start_a = 0;
    @(posedge clk); #1;
    exp_ready = 0; exp_stall = 0;
  endtask

  task automatic run_annul(input logic [31:0] a, input logic [31:0] b, input int at);
    @(posedge clk); #1;
    start_a = 1; annul_a = 0; sgn_a = 0; op1_a = a; op2_a = b;
    exp_ready = 0; exp_stall = 1;
    for (int k = 1; k <= at; k++) begin
      @(posedge clk); #1;
      if (k == at) begin annul_a = 1; exp_stall = 0; end
    end
    @(posedge clk); #1;
    annul_a = 0; start_a = 0; exp_stall = 0; exp_ready = 0;
  endtask

  task automatic run_b(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    int cyc;
    @(posedge clk); #1;
    start_b = 1; sgn_b = sgn; op1_b = a; op2_b = b;
    #1 check("b_stall_req", {63'd0, stall_b}, 64'd1);
    cyc = 0;
    while (!rdy_b && cyc < 40) begin
      @(posedge clk); #1;
      op1_b = 16'($urandom); op2_b = 16'($urandom);
      cyc++;
    end
    check("b_latency", 64'(cyc), (b == 0) ? 64'd2 : 64'd5);
    check("b_result", {32'd0, res_b}, model({16'd0, a}, {16'd0, b}, sgn, 16));
    start_b = 0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    #2 rst = 1;
    #2;
    check("rst_ready", {63'd0, rdy_a}, 64'd0);
    check("rst_result", res_a, 64'd0);
    check("rst_stall", {63'd0, stall_a}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;

    run_op(32'd100, 32'd7, 0);
    check("lit_100_7", res_a, {32'd2, 32'd14});
    run_op(32'hFFFF_FFF9, 32'd2, 1);
    check("lit_m7_2", res_a, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1);
    check("lit_min_m1", res_a, {32'd0, 32'h8000_0000});
    run_op(32'd5, 32'd0, 0);
    check("lit_div0", res_a, 64'd0);

    run_annul(32'd12345, 32'd67, 10);
    run_op(32'd9, 32'd3, 0);
    check("lit_9_3", res_a, {32'd0, 32'd3});

    // start with annul in IDLE must not be taken, even with a zero divisor
    @(posedge clk); #1;
    start_a = 1; annul_a = 1; op2_a = 0; exp_stall = 0;
    @(posedge clk); #1;
    start_a = 0; annul_a = 0;

    // asynchronous reset mid-operation
    @(posedge clk); #1;
    start_a = 1; sgn_a = 0; op1_a = 32'd777; op2_a = 32'd5; exp_stall = 1;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    chk_en = 0;
    rst = 1;
    #1;
    check("arst_ready", {63'd0, rdy_a}, 64'd0);
    check("arst_result", res_a, 64'd0);
    check("arst_stall", {63'd0, stall_a}, 64'd1);
    start_a = 0;
    #1 check("arst_stall_idle", {63'd0, stall_a}, 64'd0);
    @(posedge clk); #1;
    rst = 0; exp_res = '0; exp_ready = 0; exp_stall = 0;
    chk_en = 1;
    run_op(32'hFFFF_FFFF, 32'h10, 0);
    check("lit_ffff_10", res_a, {32'hF, 32'h0FFF_FFFF});

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = $urandom_range(1, 20);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, 1'($urandom));
    end
    chk_en = 0;

    run_b(16'd1000, 16'd33, 0);
    check("lit_b_1000_33", {32'd0, res_b}, {32'd0, 16'd10, 16'd30});
    run_b(16'hFFF9, 16'd2, 1);
    run_b(16'h8000, 16'hFFFF, 1);
    run_b(16'd7, 16'd0, 0);
    for (int i = 0; i < 20; i++) begin
      run_b(16'($urandom), 16'($urandom >> $urandom_range(0, 15)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised multi-cycle sequential divider for the MIPS core's execute stage. It serves DIV/DIVU and any wider or narrower datapath variant. A restoring division retires BITS_PER_CYCLE quotient bits per clock. It holds the pipeline through a stall request and returns {remainder, quotient} in the HI/LO packing used by the HI/LO register path. Execute-stage control drives it with a level-held start/ready handshake, and it supports annulment when the owning instruction is flushed.

## Interface
Parameters:
- DATA_W, 32, operand width in bits; legal values ≥2.
- BITS_PER_CYCLE, 1, quotient bits resolved per ON cycle; legal values are 1, 2, 4; must divide DATA_W.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- signed_i  in  1  1 = two's-complement division (DIV), 0 = unsigned division (DIVU); sampled with start.
- start_i  in  1  request; held high by the requester until ready_o is seen.
- annul_i  in  1  abort the current or requested operation.
- opdata1_i  in  DATA_W  dividend; sampled on the accepting edge only.
- opdata2_i  in  DATA_W  divisor; sampled on the accepting edge only.
- result_o  out  2*DATA_W  [2*DATA_W-1:DATA_W] = remainder, [DATA_W-1:0] = quotient.
- ready_o  out  1  result valid.
- stallreq_o  out  1  combinational request to freeze earlier pipeline stages.

## Operation
- FSM states: IDLE, BY_ZERO, ON, END. Reset state is IDLE, with result_o = 0, ready_o = 0 and the iteration counter = 0.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i=0 → BY_ZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 → ON. On this edge, latch the operand magnitudes (negate an operand when signed_i=1 and its MSB=1), latch both sign bits and signed_i, and clear the counter and partial remainder.
  - Otherwise stay in IDLE.
- BY_ZERO: load result_o = 0 and go to END after one cycle. No exception is raised; the architecture leaves this result undefined and we fix it at 0.
- ON:
  - Each cycle performs BITS_PER_CYCLE restoring steps: shift the partial remainder left by one and bring in the next dividend MSB, trial-subtract the divisor, keep the difference when it is non-negative, and shift the quotient bit in.
  - The counter increments by 1 per cycle. When the counter reaches DATA_W/BITS_PER_CYCLE-1, the final step is taken and the state moves to END.
  - On that final edge, apply the sign fixes: negate the quotient when signed and the operand signs differ; negate the remainder when signed and the dividend was negative. Then register result_o.
  - annul_i=1 in ON → IDLE on the next edge. result_o is not updated and ready_o never asserts.
- END:
  - ready_o=1 and result_o is stable.
  - start_i=0 or annul_i=1 → IDLE.
  - result_o keeps its last value until the next completion or reset.
- stallreq_o = 1 in each of these cases:
  - (IDLE and start_i and !annul_i);
  - BY_ZERO;
  - (ON and !annul_i).
  - It is 0 in every other case, including END, so the pipeline releases in the cycle ready_o is seen.
- Width rules:
  - The partial remainder is DATA_W+1 bits wide to hold the trial-subtract borrow.
  - Negation is two's complement modulo 2^DATA_W.
  - Signed MIN/-1 wraps: quotient = MIN, remainder = 0. No overflow flag is produced.
- Operand inputs may change freely after acceptance; they are ignored until the next IDLE acceptance.

## Timing
- Accepting edge = the edge that ends cycle 0.
- Non-zero divisor: ON occupies cycles 1..N, where N = DATA_W/BITS_PER_CYCLE. ready_o is high from cycle N+1. Latency is N+1 cycles (33 at the defaults).
- Zero divisor: BY_ZERO is cycle 1 and ready_o is high from cycle 2.
- Back-to-back operations: the earliest restart is the cycle after END→IDLE, so each operation costs at least one idle cycle.
- Simultaneous annul_i and start_i in IDLE: the request is not accepted and stallreq_o=0.
- Asynchronous rst in any state: IDLE immediately, with ready_o=0, result_o=0 and stallreq_o driven only by the IDLE equation.

## Test plan
- Defaults, unsigned 100/7, start held → ready_o rises 33 cycles after the accepting edge. result_o = {32'd2, 32'd14}. stallreq_o is high in cycles 0–32 and low in cycle 33.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divisor 0 (5/0) → ready_o in cycle 2, result_o = 0. Dropping start_i returns the FSM to IDLE and ready_o falls the next cycle.
- Annul in ON at cycle 10 → IDLE next edge, ready_o stays 0 and result_o keeps its prior value. A following 9/3 then completes with quotient 3, remainder 0.
- Assert rst asynchronously (between clock edges) mid-ON → all outputs clear immediately. After release, 0xFFFFFFFF/0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF.
- DATA_W=16, BITS_PER_CYCLE=4, 1000/33 unsigned → ready_o in cycle 5, quotient 30, remainder 10.
